// File: rtl/prog_seq_gen.sv
// prog_seq_gen: mode-selectable WIDTH-bit sequence generator (binary up/down, Gray, ring, Johnson, LFSR)
// with synchronous load, step enable and a one-cycle wrap pulse at the end of each period.
module prog_seq_gen #(
   parameter int              WIDTH = 4,
   parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
   parameter int              SEED  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             wrap
);
   localparam logic [2:0] M_UP   = 3'd0;
   localparam logic [2:0] M_DOWN = 3'd1;
   localparam logic [2:0] M_GRAY = 3'd2;
   localparam logic [2:0] M_RING = 3'd3;
   localparam logic [2:0] M_JOHN = 3'd4;
   localparam logic [2:0] M_LFSR = 3'd5;
   localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);
   logic [WIDTH-1:0] state, nxt, start_q, start_n, load_v;
   logic [2:0]       mode_q;
   function automatic logic [WIDTH-1:0] start_of(input logic [2:0] m);
      return m == M_DOWN ? '1 :
             m == M_RING ? WIDTH'(1) :
             m == M_LFSR ? SEED_V : '0;
   endfunction
   always_comb begin
      nxt = (mode_q == M_UP || mode_q == M_GRAY) ? state + WIDTH'(1) :
            mode_q == M_DOWN ? state - WIDTH'(1) :
            mode_q == M_RING ? {state[WIDTH-2:0], state[WIDTH-1]} :
            mode_q == M_JOHN ? {state[WIDTH-2:0], ~state[WIDTH-1]} :
            mode_q == M_LFSR ? {state[WIDTH-2:0], ^(state & TAPS)} : state;
      start_q = start_of(mode_q);
      start_n = start_of(mode);
      // an all-zero LFSR would lock up, so a zero load in that mode becomes the seed
      load_v = (mode == M_LFSR && load_val == '0) ? SEED_V : load_val;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= '0;
         mode_q <= '0;
         wrap   <= 1'b0;
      end else if (load) begin
         state  <= load_v;
         mode_q <= mode;
         wrap   <= 1'b0;
      end else if (mode != mode_q) begin
         state  <= start_n;
         mode_q <= mode;
         wrap   <= 1'b0;
      end else if (en) begin
         state  <= nxt;
         wrap   <= mode_q <= M_LFSR && nxt == start_q;
      end else begin
         wrap   <= 1'b0;
      end
   end
   assign out = mode_q == M_GRAY ? state ^ (state >> 1) : state;
endmodule

// File: doc/prog_seq_gen.md
Name: prog_seq_gen

Overview:
- Parametrised, mode-selectable sequence generator; successor to the fixed 4-bit sequence generator.
- One core produces binary up/down, Gray, ring, Johnson or LFSR sequences of width WIDTH.
- Supports synchronous load, step enable, and a one-cycle wrap pulse at the end of each period.
- Used as a pattern/stimulus source and as a cycle sequencer inside the design.

Parameters:
- WIDTH, 4, sequence width in bits (>= 2).
- TAPS, 4'b1100, LFSR feedback mask, WIDTH bits; bit i = 1 means state[i] is XORed into the feedback. Default is x^4+x^3+1, maximal length.
- SEED, 1, LFSR start value; must be non-zero.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  step enable; the sequence advances one step per clk edge while high.
- mode  input  3  0 bin-up, 1 bin-down, 2 Gray-up, 3 ring, 4 Johnson, 5 LFSR, 6/7 reserved (hold).
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value loaded into the state register.
- out  output  WIDTH  current sequence value.
- wrap  output  1  registered one-cycle pulse when a step returns the state to the mode's start value.

Behaviour:
- Registers: state[WIDTH-1:0], mode_q[2:0], wrap.
- Reset (rst low, asynchronous): state = 0, mode_q = 0, wrap = 0, so out = 0. Sequencing resumes on the first clk edge after rst goes high.
- Start value per mode:
  - bin-up, Gray, Johnson: 0
  - bin-down: all ones
  - ring: 1 (LSB one-hot)
  - LFSR: SEED
- Each clk edge, highest priority first:
  1. load: state = load_val, mode_q = mode. In LFSR mode a load_val of 0 is replaced by SEED (lock-up guard). In ring mode a value of 0 is accepted and stays 0. wrap = 0.
  2. mode != mode_q: state = start value of the new mode, mode_q = mode, wrap = 0. This is a reseed; en is ignored on this edge.
  3. en high: state = next(state) per mode_q. wrap = 1 iff next == start value of mode_q.
  4. Otherwise: hold; wrap = 0.
- next() rules, mod 2^WIDTH:
  - bin-up and Gray: state+1, wrapping max -> 0.
  - bin-down: state-1, wrapping 0 -> max.
  - ring: rotate left; MSB goes to LSB.
  - Johnson: {state[WIDTH-2:0], ~state[WIDTH-1]}.
  - LFSR: {state[WIDTH-2:0], ^(state & TAPS)}.
  - reserved modes: hold; wrap never asserts.
- Output mapping: out = state ^ (state >> 1) when mode_q = 2; otherwise out = state.
- out is a function of registers only; there is no combinational path from inputs to out or wrap.
- Latency: a change on en, load or mode is visible on out after exactly one clk edge.
- Periods for WIDTH = 4: bin 16, Gray 16, ring 4, Johnson 8, LFSR (default TAPS) 15.
- Reset asserted mid-sequence clears all registers immediately, without waiting for clk.
- wrap is high for exactly one cycle per period when en is held high. With en = 0 the state freezes and wrap = 0.

Test Plan:
- Reset, then mode = 0, en = 1 for 17 edges -> out 0,1,...,15,0; wrap high only on the cycle out returns to 0. Then drop en -> out holds and wrap = 0.
- Mode = 5 with default TAPS/SEED -> one reseed edge gives out = 0001. Subsequent out: 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, 0001; wrap asserts with the return to 0001 (period 15).
- Mode = 4 -> out 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 with wrap on the final 0000. Mode = 3 -> out 0001, 0010, 0100, 1000, 0001 with wrap on 0001.
- Mode = 2 from a load of 0 with en = 1 -> out 0000, 0001, 0011, 0010, 0110, ...; exactly one bit changes between consecutive outputs across the full 16-step period.
- Mode = 1, load = 1 with load_val = 5 while en = 1 -> load wins: out = 0101, then 0100, 0011.
- Mode = 5 with load_val = 0 -> out = 0001 (lock-up guard).
- Drive rst low between clk edges during an LFSR run -> out = 0 and wrap = 0 immediately. After release with mode still 5, the first edge reseeds to 0001.
